// File: rtl/mouse_frame_sync.sv
// mouse_frame_sync: clamps raw mouse coordinates to the visible area, collects
// left-button presses, and commits both once per frame at the start of
// vertical blanking so downstream draw logic never sees a mid-frame change.
module mouse_frame_sync #(
  parameter logic [11:0] X_MAX = 12'd1023,
  parameter logic [11:0] Y_MAX = 12'd767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_mouse_in,
  input  logic [11:0] ypos_mouse_in,
  input  logic        mouse_left_in,
  input  logic        vblnk_in,
  output logic [11:0] xpos_mouse_out,
  output logic [11:0] ypos_mouse_out,
  output logic        click_out,
  output logic        moved_out
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] pend_x, pend_y;
  logic        click_pend;
  logic        vblnk_r;     // vblnk as sampled on the edge (edge E)
  logic        vblnk_d;     // one edge older, for rise detection
  logic        left_d;
  logic        vblnk_rise;
  logic        left_rise;

  // The vblank rise is taken from the registered sample so the machine enters
  // COMMIT one edge after vblnk is first seen high; the committed position is
  // therefore the one sampled on that entry edge.
  assign vblnk_rise = vblnk_r & ~vblnk_d;
  assign left_rise  = mouse_left_in & ~left_d;

  // Clamp the raw coordinates every cycle and register the edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x  <= '0;
      pend_y  <= '0;
      vblnk_r <= 1'b0;
      vblnk_d <= 1'b0;
      left_d  <= 1'b0;
    end else begin
      pend_x  <= (xpos_mouse_in > X_MAX) ? X_MAX : xpos_mouse_in;
      pend_y  <= (ypos_mouse_in > Y_MAX) ? Y_MAX : ypos_mouse_in;
      vblnk_r <= vblnk_in;
      vblnk_d <= vblnk_r;
      left_d  <= mouse_left_in;
    end
  end

  // Sticky click flag; a press landing on the commit cycle is carried over to
  // the next frame instead of being dropped by the clear.
  always_ff @(posedge clk) begin
    if (rst)
      click_pend <= 1'b0;
    else if (state == COMMIT)
      click_pend <= left_rise;
    else if (left_rise)
      click_pend <= 1'b1;
  end

  // Frame FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACTIVE;
      xpos_mouse_out <= '0;
      ypos_mouse_out <= '0;
      click_out      <= 1'b0;
      moved_out      <= 1'b0;
    end else begin
      click_out <= 1'b0;
      moved_out <= 1'b0;
      case (state)
        ACTIVE: if (vblnk_rise) state <= COMMIT;
        COMMIT: begin
          xpos_mouse_out <= pend_x;
          ypos_mouse_out <= pend_y;
          click_out      <= click_pend;
          moved_out      <= ({pend_x, pend_y} != {xpos_mouse_out, ypos_mouse_out});
          state          <= HOLD;
        end
        HOLD:   if (!vblnk_in) state <= ACTIVE;
        default: state <= ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_frame_sync.sv
// Randomised + directed bench for mouse_frame_sync against a frame-level model.
module tb_mouse_frame_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xin, yin;
  logic        lin, vin;
  logic [11:0] xo, yo;
  logic        co, mo;

  int n_chk  = 0;
  int n_fail = 0;

  mouse_frame_sync dut (
    .clk(clk), .rst(rst),
    .xpos_mouse_in(xin), .ypos_mouse_in(yin),
    .mouse_left_in(lin), .vblnk_in(vin),
    .xpos_mouse_out(xo), .ypos_mouse_out(yo),
    .click_out(co), .moved_out(mo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-edge sample history, a press counter and the last
  // committed position. A commit happens two edges after vblnk is first seen
  // high; it publishes the clamped position sampled one edge before.
  logic [11:0] m_x, m_y;
  logic        m_c, m_m;
  int          m_press;
  logic        h1, h2, h3;
  logic        m_lprev;
  logic [11:0] m_px, m_py;

  function automatic logic [11:0] clampv(input logic [11:0] v, input logic [11:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge();
    logic commit;
    if (rst) begin
      m_x = 0; m_y = 0; m_c = 0; m_m = 0; m_press = 0;
      h1 = 0; h2 = 0; h3 = 0; m_lprev = 0; m_px = 0; m_py = 0;
      return;
    end
    commit = h2 & ~h3;
    m_c = 0; m_m = 0;
    if (commit) begin
      m_m = (m_px != m_x) || (m_py != m_y);
      m_x = m_px; m_y = m_py;
      m_c = (m_press > 0);
      m_press = 0;
    end
    if (lin && !m_lprev) m_press++;
    m_lprev = lin;
    h3 = h2; h2 = h1; h1 = vin;
    m_px = clampv(xin, 12'd1023);
    m_py = clampv(yin, 12'd767);
  endtask

  // One clock: drive inputs, model the edge, then compare all outputs.
  task automatic step(input logic r, input logic [11:0] x, input logic [11:0] y,
                      input logic l, input logic v);
    rst = r; xin = x; yin = y; lin = l; vin = v;
    @(posedge clk);
    model_edge();
    #1;
    chk("xpos", xo, m_x);
    chk("ypos", yo, m_y);
    chk("click", co, m_c);
    chk("moved", mo, m_m);
  endtask

  // Low gap, then vblnk high for hi cycles; returns outputs seen at E+2.
  task automatic frame(input logic [11:0] x, input logic [11:0] y, input logic l,
                       input int hi, output logic [11:0] cx, output logic [11:0] cy,
                       output logic cc, output logic cm);
    for (int i = 0; i < 4; i++) step(0, x, y, l, 0);
    cx = 0; cy = 0; cc = 0; cm = 0;
    for (int i = 0; i < hi + 2; i++) begin
      step(0, x, y, l, (i < hi));
      if (i == 2) begin cx = xo; cy = yo; cc = co; cm = mo; end
    end
    for (int i = 0; i < 4; i++) step(0, x, y, l, 0);
  endtask

  logic [11:0] cx, cy;
  logic        cc, cm;
  int          pulses;
  logic [11:0] rx, ry;
  logic        rl;

  initial begin
    rst = 1; xin = 0; yin = 0; lin = 0; vin = 0;
    m_x = 0; m_y = 0; m_c = 0; m_m = 0; m_press = 0;
    h1 = 0; h2 = 0; h3 = 0; m_lprev = 0; m_px = 0; m_py = 0;

    // reset with busy inputs
    for (int i = 0; i < 3; i++) step(1, 12'd500, 12'd400, 1'b1, 1'b1);
    chk("rst_x", xo, 0); chk("rst_click", co, 0);

    // basic commit and latency
    for (int i = 0; i < 4; i++) step(0, 12'd300, 12'd200, 0, 0);
    step(0, 12'd300, 12'd200, 0, 1);                          // E
    chk("e0_x", xo, 0);
    step(0, 12'd300, 12'd200, 0, 1);                          // E+1
    chk("e1_x", xo, 0); chk("e1_moved", mo, 0);
    step(0, 12'd300, 12'd200, 0, 1);                          // E+2
    chk("e2_x", xo, 300); chk("e2_y", yo, 200);
    chk("e2_moved", mo, 1); chk("e2_click", co, 0);
    step(0, 12'd300, 12'd200, 0, 1);                          // E+3
    chk("e3_moved", mo, 0);
    for (int i = 0; i < 4; i++) step(0, 12'd300, 12'd200, 0, 0);

    // stability during the active region, then commit of the E+1 sample
    for (int i = 0; i <= 2000; i += 50) begin
      step(0, 12'(i), 12'd5, 0, 0);
      chk("stable_x", xo, 300);
    end
    step(0, 12'd777, 12'd5, 0, 1);                            // E
    step(0, 12'd111, 12'd6, 0, 1);                            // E+1
    step(0, 12'd222, 12'd7, 0, 1);                            // E+2
    chk("e1sample_x", xo, 111); chk("e1sample_y", yo, 6); chk("e1sample_mv", mo, 1);
    for (int i = 0; i < 4; i++) step(0, 12'd222, 12'd7, 0, 0);

    // clamping
    frame(12'd1500, 12'd900, 0, 3, cx, cy, cc, cm);
    chk("clamp_x", cx, 1023); chk("clamp_y", cy, 767); chk("clamp_mv", cm, 1);
    frame(12'd1023, 12'd767, 0, 3, cx, cy, cc, cm);
    chk("max_x", cx, 1023); chk("max_y", cy, 767); chk("same_mv", cm, 0);
    frame(12'd4095, 12'd4095, 0, 3, cx, cy, cc, cm);
    chk("top_x", cx, 1023); chk("top_y", cy, 767); chk("top_mv", cm, 0);

    // two presses -> one click; then none
    step(0, 12'd10, 12'd10, 1, 0); step(0, 12'd10, 12'd10, 0, 0);
    step(0, 12'd10, 12'd10, 1, 0); step(0, 12'd10, 12'd10, 0, 0);
    frame(12'd10, 12'd10, 0, 3, cx, cy, cc, cm);
    chk("two_press_click", cc, 1);
    frame(12'd10, 12'd10, 0, 3, cx, cy, cc, cm);
    chk("no_press_click", cc, 0);

    // earlier press plus a press rising in the COMMIT cycle
    step(0, 12'd20, 12'd20, 1, 0); step(0, 12'd20, 12'd20, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 12'd20, 12'd20, 0, 0);
    step(0, 12'd20, 12'd20, 0, 1);                            // E
    step(0, 12'd20, 12'd20, 0, 1);                            // E+1, COMMIT
    step(0, 12'd20, 12'd20, 1, 1);                            // E+2, rise seen in COMMIT
    chk("commit_click", co, 1);
    step(0, 12'd20, 12'd20, 1, 0);
    frame(12'd20, 12'd20, 1, 3, cx, cy, cc, cm);
    chk("carried_click", cc, 1);
    step(0, 12'd20, 12'd20, 0, 0);

    // 1-cycle vblnk pulse, position changing every cycle
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 12'(40 + i), 12'd30, 0, (i == 4));
      pulses += int'(mo);
    end
    chk("short_vb_commits", pulses, 1);

    // vblnk stuck high for a long stretch
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      step(0, 12'(60 + i), 12'd30, 0, (i >= 4));
      pulses += int'(mo);
    end
    chk("stuck_vb_commits", pulses, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 12'(400 + i), 12'd31, 0, (i >= 5));
      pulses += int'(mo);
    end
    chk("resume_commits", pulses, 1);
    for (int i = 0; i < 4; i++) step(0, 12'd5, 12'd5, 0, 0);

    // reset asserted on the COMMIT exit edge
    step(1, 12'd0, 12'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 12'd333, 12'd444, 1, 0);
    step(0, 12'd333, 12'd444, 0, 1);                          // E
    step(0, 12'd333, 12'd444, 0, 1);                          // E+1, COMMIT
    step(1, 12'd333, 12'd444, 0, 1);                          // reset on exit edge
    chk("rst_commit_x", xo, 0); chk("rst_commit_mv", mo, 0); chk("rst_commit_clk", co, 0);
    step(0, 12'd333, 12'd444, 0, 1);
    chk("rst_commit_mv2", mo, 0);
    for (int i = 0; i < 4; i++) step(0, 12'd333, 12'd444, 0, 0);

    // randomised frames
    rx = 12'd100; ry = 12'd100; rl = 0;
    for (int f = 0; f < 60; f++) begin
      int lo, hi;
      lo = $urandom_range(4, 20);
      hi = $urandom_range(1, 15);
      for (int i = 0; i < lo + hi; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 4))
            0: rx = 12'($urandom);
            1: rx = 12'd1023;
            2: rx = 12'd1024;
            3: rx = 12'd4095;
            default: rx = 12'd0;
          endcase
          case ($urandom_range(0, 3))
            0: ry = 12'($urandom);
            1: ry = 12'd767;
            2: ry = 12'd768;
            default: ry = 12'd0;
          endcase
        end
        if ($urandom_range(0, 2) == 0) rl = ~rl;
        step(($urandom_range(0, 299) == 0), rx, ry, rl, (i >= lo));
      end
    end
    for (int i = 0; i < 6; i++) step(0, rx, ry, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
